// File: rtl/prom_read_arbiter_pkg.sv
// Purpose: shared types and default geometry for the boot pROM read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prom_arb_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int SIG_LEN_DEF = 3;
    // Byte k of the signature lives in bits 8k+7:8k and is expected at ROM address k.
    localparam logic [SIG_LEN_DEF*DATA_W_DEF-1:0] SIG_VALUE_DEF = 24'hF055AA;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CHECK,
        ST_DRAIN,
        ST_RUN,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/prom_read_arbiter_if.sv
// Purpose: requester handshakes, status flags and ROM macro pins of the pROM arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr until their gnt; the arbiter is the slave side.
interface prom_read_arbiter_if
    import prom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              rom_ok;
    logic              rom_err;
    logic              rom_ce;
    logic              rom_oce;
    logic              rom_reset;
    logic [ADDR_W-1:0] rom_ad;
    logic [DATA_W-1:0] rom_dout;

    // Requesters plus ROM macro wrapper.
    modport master (
        output req0, addr0, req1, addr1, rom_dout,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, rom_ok, rom_err,
        input  rom_ce, rom_oce, rom_reset, rom_ad
    );

    // The arbiter itself.
    modport slave (
        input  req0, addr0, req1, addr1, rom_dout,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, rom_ok, rom_err,
        output rom_ce, rom_oce, rom_reset, rom_ad
    );

endinterface

// File: rtl/prom_read_arbiter_grant.sv
// Purpose: 2-way grant for the single ROM read port; fixed priority to port 0, or round-robin
//          when PROM_ARB_RR_EN is defined.
// Latency: combinational grant; backpressure: a losing requester simply keeps its req high.
module prom_arb_grant (
`ifdef PROM_ARB_RR_EN
    input  logic clk,
    input  logic reset_n,
`endif
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef PROM_ARB_RR_EN
    // 1 = port 1 was granted most recently; resetting to 1 lets port 0 win the first tie.
    logic last_gnt;

    // Track which port took the last grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_gnt <= gnt1;
        end
    end

    // On a tie, favour the port that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end
`else
    // Port 0 always wins a tie.
    always_comb begin
        gnt0 = en & req0;
        gnt1 = en & req1 & ~req0;
    end
`endif

endmodule

// File: rtl/prom_read_arbiter.sv
// Purpose: owns the 16x8 boot pROM, runs a post-reset signature check, then shares the read
//          port between two requesters (PROM_ARB_RR_EN selects round-robin over fixed priority).
// Latency/backpressure: rvalid one cycle after gnt, 1 read/cycle; requesters hold until gnt.
module prom_read_arbiter
    import prom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SIG_LEN = SIG_LEN_DEF,
    parameter logic [SIG_LEN*DATA_W-1:0] SIG_VALUE = SIG_VALUE_DEF
) (
    input  logic clk,
    input  logic reset_n,
    prom_read_arbiter_if.slave bus
);

    localparam int CNT_W = (SIG_LEN > 1) ? $clog2(SIG_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_LEN - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  sig_cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              chk_issue;
    logic              serve;
    logic              init_rst;
    logic              set_ok;
    logic              set_err;

    logic              chk_vld;
    logic [CNT_W-1:0]  chk_idx;
    logic              mismatch;
    logic              cur_mis;
    logic              ok_q;
    logic              err_q;

    logic              g0;
    logic              g1;
    logic              rv0_q;
    logic              rv1_q;
    logic [ADDR_W-1:0] ad_q;
    logic [ADDR_W-1:0] rom_ad_c;

    // A signature byte is checked the cycle after its address was presented to the ROM.
    assign cur_mis = chk_vld && (bus.rom_dout != SIG_VALUE[int'(chk_idx)*DATA_W +: DATA_W]);

    // State register and signature address counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            sig_cnt <= '0;
        end else begin
            state   <= state_n;
            sig_cnt <= cnt_n;
        end
    end

    // Next state and per-state controls: boot check first, then serve reads forever.
    always_comb begin
        state_n   = state;
        cnt_n     = sig_cnt;
        chk_issue = 1'b0;
        serve     = 1'b0;
        init_rst  = 1'b0;
        set_ok    = 1'b0;
        set_err   = 1'b0;
        case (state)
            ST_INIT: begin
                init_rst = 1'b1;
                state_n  = ST_CHECK;
            end
            ST_CHECK: begin
                chk_issue = 1'b1;
                cnt_n     = sig_cnt + 1'b1;
                if (sig_cnt == CNT_LAST) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mismatch || cur_mis) begin
                    set_err = 1'b1;
                    state_n = ST_FAIL;
                end else begin
                    set_ok  = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN, ST_FAIL: begin
                serve = 1'b1;
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase
    end

    // Signature compare pipeline and sticky result flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_vld  <= 1'b0;
            chk_idx  <= '0;
            mismatch <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chk_vld <= chk_issue;
            chk_idx <= sig_cnt;
            if (cur_mis) begin
                mismatch <= 1'b1;
            end
            if (set_ok) begin
                ok_q <= 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    prom_arb_grant u_grant (
`ifdef PROM_ARB_RR_EN
        .clk     (clk),
        .reset_n (reset_n),
`endif
        .en      (serve),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .gnt0    (g0),
        .gnt1    (g1)
    );

    // ROM address: signature walk, else the granted port, else hold the last issued address.
    always_comb begin
        rom_ad_c = ad_q;
        if (chk_issue) begin
            rom_ad_c = ADDR_W'(sig_cnt);
        end else if (g0) begin
            rom_ad_c = bus.addr0;
        end else if (g1) begin
            rom_ad_c = bus.addr1;
        end
    end

    // Return pipeline: rvalid follows gnt by one cycle, matching the ROM's bypass read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            ad_q  <= '0;
        end else begin
            rv0_q <= g0;
            rv1_q <= g1;
            if (bus.rom_ce) begin
                ad_q <= rom_ad_c;
            end
        end
    end

    assign bus.gnt0      = g0;
    assign bus.gnt1      = g1;
    assign bus.rvalid0   = rv0_q;
    assign bus.rvalid1   = rv1_q;
    assign bus.rdata     = (rv0_q || rv1_q) ? bus.rom_dout : '0;
    assign bus.rom_ok    = ok_q;
    assign bus.rom_err   = err_q;
    assign bus.rom_ce    = chk_issue | g0 | g1;
    assign bus.rom_oce   = 1'b1;
    assign bus.rom_reset = init_rst | ~reset_n;
    assign bus.rom_ad    = rom_ad_c;

endmodule

// File: tb/tb_prom_read_arbiter.sv
// Purpose: directed check of boot signature, arbitration, return latency and mid-op reset.
// Latency: reads return one cycle after grant through a bypass-mode ROM model.
// Backpressure: requesters hold req/addr until granted.
module tb_prom_read_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [7:0] rom_mem [16];
    logic [7:0] rom_q;

    prom_read_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prom_read_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Bypass-mode ROM macro: data appears the cycle after ce is sampled high.
    always @(posedge clk) begin
        if (bus.rom_reset) begin
            rom_q <= 8'h00;
        end else if (bus.rom_ce) begin
            rom_q <= rom_mem[bus.rom_ad];
        end
    end
    assign bus.rom_dout = rom_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then confirm every output sits at its reset value.
    task automatic do_reset();
        reset_n   = 1'b0;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = 4'd0;
        bus.addr1 = 4'd0;
        tick();
        tick();
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 0);
        chk("rst_rom_ok", 32'(bus.rom_ok), 0);
        chk("rst_rom_err", 32'(bus.rom_err), 0);
        chk("rst_rom_ce", 32'(bus.rom_ce), 0);
        chk("rst_rom_oce", 32'(bus.rom_oce), 1);
        chk("rst_rom_reset", 32'(bus.rom_reset), 1);
        chk("rst_rom_ad", 32'(bus.rom_ad), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
    endtask

    // Release reset with both ports requesting; walk edges 1..5 of the signature check.
    task automatic boot(input logic exp_ok);
        @(negedge clk);
        reset_n   = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr0 = 4'd5;
        bus.addr1 = 4'd7;
        #1;
        chk("init_rom_reset", 32'(bus.rom_reset), 1);
        chk("init_rom_ce", 32'(bus.rom_ce), 0);
        chk("init_gnt0", 32'(bus.gnt0), 0);
        tick();
        chk("e1_rom_reset", 32'(bus.rom_reset), 0);
        chk("e1_rom_ce", 32'(bus.rom_ce), 1);
        chk("e1_rom_ad", 32'(bus.rom_ad), 0);
        chk("e1_gnt0", 32'(bus.gnt0), 0);
        chk("e1_gnt1", 32'(bus.gnt1), 0);
        tick();
        chk("e2_rom_ce", 32'(bus.rom_ce), 1);
        chk("e2_rom_ad", 32'(bus.rom_ad), 1);
        chk("e2_gnt0", 32'(bus.gnt0), 0);
        tick();
        chk("e3_rom_ce", 32'(bus.rom_ce), 1);
        chk("e3_rom_ad", 32'(bus.rom_ad), 2);
        chk("e3_gnt1", 32'(bus.gnt1), 0);
        tick();
        chk("e4_rom_ce", 32'(bus.rom_ce), 0);
        chk("e4_gnt0", 32'(bus.gnt0), 0);
        chk("e4_gnt1", 32'(bus.gnt1), 0);
        chk("e4_rom_ok", 32'(bus.rom_ok), 0);
        chk("e4_rom_err", 32'(bus.rom_err), 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        chk("e5_rom_ok", 32'(bus.rom_ok), 32'(exp_ok));
        chk("e5_rom_err", 32'(bus.rom_err), 32'(!exp_ok));
    endtask

    initial begin
        logic e0;
        logic e1;
        logic pg0;
        logic pg1;
        logic rr;
`ifdef PROM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        pg0 = 1'b0;
        pg1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rom_mem[i] = 8'hC0 | 8'(i);
        end
        rom_mem[0] = 8'hAA;
        rom_mem[1] = 8'h55;
        rom_mem[2] = 8'hF0;
        rom_mem[3] = 8'h33;
        rom_mem[5] = 8'h11;
        rom_mem[7] = 8'h77;
        rom_mem[8] = 8'h88;
        rom_mem[9] = 8'h99;

        // Good signature.
        do_reset();
        boot(1'b1);

        // Single read on port 0.
        bus.req0  = 1'b1;
        bus.addr0 = 4'd5;
        #1;
        chk("r0_gnt0", 32'(bus.gnt0), 1);
        chk("r0_gnt1", 32'(bus.gnt1), 0);
        chk("r0_rom_ce", 32'(bus.rom_ce), 1);
        chk("r0_rom_ad", 32'(bus.rom_ad), 5);
        tick();
        bus.req0 = 1'b0;
        chk("r0_rvalid0", 32'(bus.rvalid0), 1);
        chk("r0_rvalid1", 32'(bus.rvalid1), 0);
        chk("r0_rdata", 32'(bus.rdata), 32'h11);
        tick();
        chk("r0_rvalid0_off", 32'(bus.rvalid0), 0);

        // Back-to-back reads on port 1.
        bus.req1  = 1'b1;
        bus.addr1 = 4'd7;
        #1;
        chk("b2b_gnt1_a", 32'(bus.gnt1), 1);
        chk("b2b_ce_a", 32'(bus.rom_ce), 1);
        chk("b2b_ad_a", 32'(bus.rom_ad), 7);
        tick();
        bus.addr1 = 4'd8;
        #1;
        chk("b2b_ce_b", 32'(bus.rom_ce), 1);
        chk("b2b_ad_b", 32'(bus.rom_ad), 8);
        chk("b2b_rvalid1_a", 32'(bus.rvalid1), 1);
        chk("b2b_rdata_a", 32'(bus.rdata), 32'h77);
        tick();
        bus.addr1 = 4'd9;
        #1;
        chk("b2b_ce_c", 32'(bus.rom_ce), 1);
        chk("b2b_ad_c", 32'(bus.rom_ad), 9);
        chk("b2b_rvalid1_b", 32'(bus.rvalid1), 1);
        chk("b2b_rdata_b", 32'(bus.rdata), 32'h88);
        tick();
        bus.req1 = 1'b0;
        #1;
        chk("b2b_rvalid1_c", 32'(bus.rvalid1), 1);
        chk("b2b_rdata_c", 32'(bus.rdata), 32'h99);
        chk("idle_rom_ce", 32'(bus.rom_ce), 0);
        chk("idle_rom_ad_hold", 32'(bus.rom_ad), 9);
        tick();
        chk("b2b_rvalid1_off", 32'(bus.rvalid1), 0);

        // Both ports requesting for four cycles.
        bus.req0  = 1'b1;
        bus.addr0 = 4'd3;
        bus.req1  = 1'b1;
        bus.addr1 = 4'd8;
        #1;
        for (int i = 0; i < 4; i++) begin
            e0 = rr ? (i % 2 == 0) : 1'b1;
            e1 = ~e0;
            chk("cont_gnt0", 32'(bus.gnt0), 32'(e0));
            chk("cont_gnt1", 32'(bus.gnt1), 32'(e1));
            chk("cont_rom_ad", 32'(bus.rom_ad), e0 ? 32'd3 : 32'd8);
            if (i > 0) begin
                chk("cont_rvalid0", 32'(bus.rvalid0), 32'(pg0));
                chk("cont_rvalid1", 32'(bus.rvalid1), 32'(pg1));
                chk("cont_rdata", 32'(bus.rdata), pg0 ? 32'h33 : 32'h88);
            end
            pg0 = e0;
            pg1 = e1;
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        chk("cont_last_rvalid0", 32'(bus.rvalid0), 32'(pg0));
        chk("cont_last_rvalid1", 32'(bus.rvalid1), 32'(pg1));
        chk("cont_last_rdata", 32'(bus.rdata), pg0 ? 32'h33 : 32'h88);
        chk("cont_gnt0_off", 32'(bus.gnt0), 0);
        tick();

        // Corrupted signature byte 1: failure is flagged but reads are still served.
        rom_mem[1] = 8'h54;
        do_reset();
        boot(1'b0);
        bus.req0  = 1'b1;
        bus.addr0 = 4'd3;
        #1;
        chk("fail_gnt0", 32'(bus.gnt0), 1);
        tick();
        bus.req0 = 1'b0;
        chk("fail_rvalid0", 32'(bus.rvalid0), 1);
        chk("fail_rdata", 32'(bus.rdata), 32'h33);
        chk("fail_err_sticky", 32'(bus.rom_err), 1);

        // Reset lands while a read is in flight.
        rom_mem[1] = 8'h55;
        do_reset();
        boot(1'b1);
        bus.req0  = 1'b1;
        bus.addr0 = 4'd5;
        #1;
        chk("mid_gnt0", 32'(bus.gnt0), 1);
        tick();
        reset_n  = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("mid_rvalid0", 32'(bus.rvalid0), 0);
        chk("mid_rdata", 32'(bus.rdata), 0);
        chk("mid_rom_ok", 32'(bus.rom_ok), 0);
        chk("mid_rom_reset", 32'(bus.rom_reset), 1);
        chk("mid_rom_ad", 32'(bus.rom_ad), 0);
        chk("mid_rom_ce", 32'(bus.rom_ce), 0);
        tick();
        chk("mid_rvalid0_after", 32'(bus.rvalid0), 0);
        boot(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
